// File: rtl/alu_seq_pkg.sv
// Shared opcode and state definitions for the chunked ALU sequencer.
// The opcode encoding doubles as the 3-bit selector of the alu_chunk slice.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_XOR  = 3'd2,
    OP_SLT  = 3'd3,
    OP_AND  = 3'd4,
    OP_NAND = 3'd5,
    OP_NOR  = 3'd6,
    OP_OR   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_chunk.sv
// One CHUNK-bit combinational ALU slice: ripple add/sub with carry chaining,
// bitwise logic, and an MSB-first signed-compare step carrying eq/ans state.
module alu_chunk
  import alu_seq_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  op_e              op,
  input  logic             carry_in,
  input  logic             eq_in,
  input  logic             ans_in,
  input  logic             top,
  output logic [CHUNK-1:0] result,
  output logic             carry_out,
  output logic             eq_out,
  output logic             ans_out
);

  logic [CHUNK-1:0] b_eff;
  logic [CHUNK:0]   sum;

  always_comb begin
    b_eff     = (op == OP_SUB) ? ~b : b;
    sum       = {1'b0, a} + {1'b0, b_eff} + {{CHUNK{1'b0}}, carry_in};
    result    = '0;
    carry_out = 1'b0;
    eq_out    = eq_in;
    ans_out   = ans_in;
    case (op)
      OP_ADD, OP_SUB: begin
        result    = sum[CHUNK-1:0];
        carry_out = sum[CHUNK];
      end
      OP_XOR:  result = a ^ b;
      OP_AND:  result = a & b;
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_OR:   result = a | b;
      OP_SLT: begin
        // The first differing bit decides; on the sign bit a set 'a' means a is negative.
        for (int i = CHUNK - 1; i >= 0; i--) begin
          if (eq_out && (a[i] != b[i])) begin
            eq_out  = 1'b0;
            ans_out = (top && (i == CHUNK - 1)) ? a[i] : (~a[i] & b[i]);
          end
        end
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_chunk_sequencer.sv
// Time-shares one CHUNK-bit ALU slice across a WIDTH-bit operation (IDLE/RUN/DONE).
// Define ALU_SEQ_EARLY_EXIT_EN to let SLT finish as soon as its answer is decided.
module alu_chunk_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_overflow,
  output logic             out_zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d, idx;
  logic             carry_q, carry_d, eq_q, eq_d, ans_q, ans_d;
  logic [WIDTH-1:0] out_result_q, out_result_d;
  logic             out_carry_q, out_carry_d;
  logic             out_overflow_q, out_overflow_d;
  logic             out_zero_q, out_zero_d;
  logic             in_ready_c, finish;
  logic [WIDTH-1:0] final_res;

  logic [CHUNK-1:0] chk_a, chk_b, chk_result;
  logic             chk_carry, chk_eq, chk_ans, chk_top;

  // SLT walks MSB-first so the sign chunk is seen first; everything else goes LSB-first.
  always_comb begin
    idx     = (op_q == OP_SLT) ? (CW'(NCHUNK - 1) - cnt_q) : cnt_q;
    chk_a   = a_q[idx*CHUNK +: CHUNK];
    chk_b   = b_q[idx*CHUNK +: CHUNK];
    chk_top = (idx == CW'(NCHUNK - 1));
  end

  alu_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a         (chk_a),
    .b         (chk_b),
    .op        (op_q),
    .carry_in  (carry_q),
    .eq_in     (eq_q),
    .ans_in    (ans_q),
    .top       (chk_top),
    .result    (chk_result),
    .carry_out (chk_carry),
    .eq_out    (chk_eq),
    .ans_out   (chk_ans)
  );

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    a_d            = a_q;
    b_d            = b_q;
    res_d          = res_q;
    cnt_d          = cnt_q;
    carry_d        = carry_q;
    eq_d           = eq_q;
    ans_d          = ans_q;
    out_result_d   = out_result_q;
    out_carry_d    = out_carry_q;
    out_overflow_d = out_overflow_q;
    out_zero_d     = out_zero_q;
    in_ready_c     = 1'b0;
    out_valid      = 1'b0;
    finish         = 1'b0;
    final_res      = '0;
    case (state_q)
      S_IDLE: begin
        in_ready_c = 1'b1;
        if (in_valid) begin
          op_d    = op_e'(in_op);
          a_d     = in_a;
          b_d     = in_b;
          res_d   = '0;
          cnt_d   = '0;
          carry_d = (op_e'(in_op) == OP_SUB);
          eq_d    = 1'b1;
          ans_d   = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        res_d[idx*CHUNK +: CHUNK] = chk_result;
        carry_d = chk_carry;
        eq_d    = chk_eq;
        ans_d   = chk_ans;
        cnt_d   = cnt_q + 1'b1;
        finish  = (cnt_q == CW'(NCHUNK - 1));
`ifdef ALU_SEQ_EARLY_EXIT_EN
        if ((op_q == OP_SLT) && !chk_eq) finish = 1'b1;
`endif
        if (finish) begin
          final_res      = (op_q == OP_SLT) ? {{(WIDTH-1){1'b0}}, chk_ans} : res_d;
          out_result_d   = final_res;
          out_zero_d     = (final_res == '0);
          out_carry_d    = 1'b0;
          out_overflow_d = 1'b0;
          if (op_q == OP_ADD) begin
            out_carry_d    = chk_carry;
            out_overflow_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (final_res[WIDTH-1] != a_q[WIDTH-1]);
          end else if (op_q == OP_SUB) begin
            out_carry_d    = chk_carry;
            out_overflow_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (final_res[WIDTH-1] != a_q[WIDTH-1]);
          end
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      op_q           <= OP_ADD;
      a_q            <= '0;
      b_q            <= '0;
      res_q          <= '0;
      cnt_q          <= '0;
      carry_q        <= 1'b0;
      eq_q           <= 1'b0;
      ans_q          <= 1'b0;
      out_result_q   <= '0;
      out_carry_q    <= 1'b0;
      out_overflow_q <= 1'b0;
      out_zero_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      a_q            <= a_d;
      b_q            <= b_d;
      res_q          <= res_d;
      cnt_q          <= cnt_d;
      carry_q        <= carry_d;
      eq_q           <= eq_d;
      ans_q          <= ans_d;
      out_result_q   <= out_result_d;
      out_carry_q    <= out_carry_d;
      out_overflow_q <= out_overflow_d;
      out_zero_q     <= out_zero_d;
    end
  end

  assign in_ready     = in_ready_c & rst_n;
  assign out_result   = out_result_q;
  assign out_carry    = out_carry_q;
  assign out_overflow = out_overflow_q;
  assign out_zero     = out_zero_q;

endmodule

// File: tb/tb_alu_chunk_sequencer.sv
// Directed self-checking bench for alu_chunk_sequencer with hand-computed results.
// Latency expectations for SLT follow ALU_SEQ_EARLY_EXIT_EN when it is defined.
module tb_alu_chunk_sequencer;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, XOR = 3'd2, SLT = 3'd3,
                         AND = 3'd4, NAND = 3'd5, NOR = 3'd6, OR = 3'd7;

`ifdef ALU_SEQ_EARLY_EXIT_EN
  localparam int SLT_FAST_LAT = 1;
`else
  localparam int SLT_FAST_LAT = 8;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_a, in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_carry, out_overflow, out_zero;

  int checks = 0;
  int errors = 0;
  int lat;

  always #5 clk = ~clk;

  alu_chunk_sequencer #(.WIDTH(32), .CHUNK(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_a         (in_a),
    .in_b         (in_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_carry    (out_carry),
    .out_overflow (out_overflow),
    .out_zero     (out_zero)
  );

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for in_ready, issues one request, and counts cycles until out_valid.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               output int latency);
    int guard;
    guard = 0;
    while (!in_ready && guard < 30) begin
      @(posedge clk); #1;
      guard++;
    end
    checkValue("accept_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    latency  = 0;
    while (!out_valid && latency < 40) begin
      @(posedge clk); #1;
      latency++;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] exp_res, input logic exp_c,
                             input logic exp_o, input int exp_lat, input int latency);
    checkValue({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    checkValue({tag, "_result"}, out_result, exp_res);
    checkValue({tag, "_carry"}, {31'd0, out_carry}, {31'd0, exp_c});
    checkValue({tag, "_overflow"}, {31'd0, out_overflow}, {31'd0, exp_o});
    checkValue({tag, "_zero"}, {31'd0, out_zero}, {31'd0, (exp_res == 32'd0)});
    checkValue({tag, "_latency"}, latency, exp_lat);
  endtask

  task automatic releaseResult(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkValue({tag, "_rel_valid"}, {31'd0, out_valid}, 32'd0);
    checkValue({tag, "_rel_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] held;
    logic        saw_valid;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 3'd0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkValue("rst_in_ready", {31'd0, in_ready}, 32'd0);
    checkValue("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkValue("rst_out_result", out_result, 32'd0);
    checkValue("rst_flags", {29'd0, out_carry, out_overflow, out_zero}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkValue("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    applyStimulus(ADD, 32'hFFFFFFFF, 32'h00000001, lat);
    checkOutput("add_wrap", 32'h00000000, 1'b1, 1'b0, 8, lat);
    releaseResult("add_wrap");

    applyStimulus(SUB, 32'h80000000, 32'h00000001, lat);
    checkOutput("sub_ovf", 32'h7FFFFFFF, 1'b1, 1'b1, 8, lat);
    releaseResult("sub_ovf");

    applyStimulus(SUB, 32'd5, 32'd5, lat);
    checkOutput("sub_eq", 32'h00000000, 1'b1, 1'b0, 8, lat);
    releaseResult("sub_eq");

    applyStimulus(SLT, 32'hFFFFFFFF, 32'h00000001, lat);
    checkOutput("slt_neg", 32'h00000001, 1'b0, 1'b0, SLT_FAST_LAT, lat);
    releaseResult("slt_neg");

    applyStimulus(SLT, 32'd5, 32'd5, lat);
    checkOutput("slt_eq", 32'h00000000, 1'b0, 1'b0, 8, lat);
    releaseResult("slt_eq");

    applyStimulus(SLT, 32'h00000010, 32'h00000011, lat);
    checkOutput("slt_low", 32'h00000001, 1'b0, 1'b0, 8, lat);
    releaseResult("slt_low");

    applyStimulus(AND, 32'hF0F0F0F0, 32'hFF00FF00, lat);
    checkOutput("and", 32'hF000F000, 1'b0, 1'b0, 8, lat);
    releaseResult("and");
    applyStimulus(NAND, 32'hF0F0F0F0, 32'hFF00FF00, lat);
    checkOutput("nand", 32'h0FFF0FFF, 1'b0, 1'b0, 8, lat);
    releaseResult("nand");
    applyStimulus(OR, 32'hF0F0F0F0, 32'hFF00FF00, lat);
    checkOutput("or", 32'hFFF0FFF0, 1'b0, 1'b0, 8, lat);
    releaseResult("or");
    applyStimulus(NOR, 32'hF0F0F0F0, 32'hFF00FF00, lat);
    checkOutput("nor", 32'h000F000F, 1'b0, 1'b0, 8, lat);
    releaseResult("nor");
    applyStimulus(XOR, 32'hF0F0F0F0, 32'hFF00FF00, lat);
    checkOutput("xor", 32'h0FF00FF0, 1'b0, 1'b0, 8, lat);
    releaseResult("xor");

    // Hold the result in DONE for five cycles while poking in_valid.
    applyStimulus(ADD, 32'h7FFFFFFF, 32'h00000001, lat);
    checkOutput("add_hold", 32'h80000000, 1'b0, 1'b1, 8, lat);
    held = 32'h80000000;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 1 || i == 2);
      in_op    = XOR;
      in_a     = 32'h12345678;
      in_b     = 32'h0000FFFF;
      @(posedge clk); #1;
      checkValue("hold_valid", {31'd0, out_valid}, 32'd1);
      checkValue("hold_result", out_result, held);
      checkValue("hold_flags", {29'd0, out_carry, out_overflow, out_zero}, 32'd2);
      checkValue("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    releaseResult("hold");
    @(posedge clk); #1;
    checkValue("hold_no_ghost", {31'd0, out_valid}, 32'd0);
    applyStimulus(XOR, 32'h12345678, 32'h0000FFFF, lat);
    checkOutput("after_hold", 32'h1234A987, 1'b0, 1'b0, 8, lat);
    releaseResult("after_hold");

    // Abandon an operation with reset during its third RUN cycle.
    in_valid = 1'b1;
    in_op    = ADD;
    in_a     = 32'h11111111;
    in_b     = 32'h22222222;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkValue("run_in_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checkValue("inrst_in_ready", {31'd0, in_ready}, 32'd0);
      saw_valid |= out_valid;
    end
    rst_n = 1'b1;
    #1;
    checkValue("rel_in_ready", {31'd0, in_ready}, 32'd1);
    checkValue("rel_out_result", out_result, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      saw_valid |= out_valid;
    end
    checkValue("abandon_no_valid", {31'd0, saw_valid}, 32'd0);
    applyStimulus(ADD, 32'd2, 32'd3, lat);
    checkOutput("add_after_rst", 32'd5, 1'b0, 1'b0, 8, lat);
    releaseResult("add_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_chunk_sequencer.md
# alu_chunk_sequencer

Multicycle controller that time-shares one CHUNK-bit ALU slice across a WIDTH-bit operation. It accepts an operation and operands over a valid/ready handshake, then steps the slice chunk by chunk. For add/sub/logic it steps LSB-first, carrying the adder carry between chunks. For SLT it steps MSB-first, carrying the "equal so far" and "answer decided" state between chunks. It sits between an instruction source and the register file, in place of a full-width combinational ALU, trading latency for area.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of CHUNK
- CHUNK, 4, bits processed per cycle; NCHUNK = WIDTH/CHUNK
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  request present
- in_ready  output  1  block can accept a request
- in_op  input  3  0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR
- in_a, in_b  input  WIDTH  operands, two's complement
- out_valid  output  1  result available
- out_ready  input  1  consumer takes the result
- out_result  output  WIDTH  result
- out_carry  output  1  carry out of the MSB (ADD/SUB only, else 0)
- out_overflow  output  1  signed overflow (ADD/SUB only, else 0)
- out_zero  output  1  out_result == 0

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - in_ready = 1.
  - On in_valid, latch op, a and b; clear the chunk counter; go to RUN.
- **RUN**
  - in_ready = 0.
  - Each cycle, one chunk is computed and written into its result field; the counter increments.
  - ADD/SUB/logic use chunk index = counter (LSB-first).
  - SLT uses chunk index = NCHUNK-1-counter (MSB-first).
  - SUB = a + ~b with carry-in 1. ADD carry-in = 0. The carry register is forwarded chunk to chunk.
  - SLT is signed and uses an eq flag (init 1) and an ans flag (init 0).
    - Top chunk, sign bits differ: ans = a_msb, eq = 0.
    - Otherwise, the first unequal bit pair going down sets ans = (a_bit < b_bit) and eq = 0.
    - After the decision, ans and eq are frozen.
    - Final result = {WIDTH-1 zeros, ans}. Equal operands give 0.
  - After the NCHUNK-th chunk, compute the flags and go to DONE.
    - ADD overflow = (a_msb == b_msb) && (r_msb != a_msb).
    - SUB overflow = (a_msb != b_msb) && (r_msb != a_msb).
    - SUB carry = 1 means no borrow.
- **DONE**
  - out_valid = 1; outputs held stable.
  - On out_ready, go to IDLE.
  - in_valid is ignored until IDLE.
- **Reset**
  - rst_n low on any edge forces IDLE and clears all registers.
  - An operation in flight is abandoned and produces no out_valid.
  - in_ready is 0 while rst_n is low.
- **Reset values:** out_valid 0, out_result 0, out_carry 0, out_overflow 0, out_zero 0, in_ready 0 (1 from the first cycle after rst_n rises).

## Timing
- Accepting edge E (in_valid && in_ready).
- RUN occupies the NCHUNK cycles after E.
- out_valid rises after edge E+NCHUNK. Latency is NCHUNK cycles (8 at defaults).
- The DONE→IDLE edge is the out_ready edge. in_ready rises in the following cycle.
- Minimum spacing between accepts is NCHUNK+2 cycles (out_ready held high).
- out_* change only on the RUN→DONE edge and on reset.
- The single-cycle ADD/SUB path is one CHUNK-bit ripple plus carry mux.

## Configuration
- ALU_SEQ_EARLY_EXIT_EN
- Defined:
  - SLT goes to DONE on the edge following the chunk where eq clears. Latency is k+1 cycles, with k the zero-based MSB-first chunk index of the decision.
  - Equal operands still take NCHUNK cycles.
  - Other ops are unchanged.
- Undefined: every op takes exactly NCHUNK cycles.

## Structure
- Package alu_seq_pkg holds:
  - the opcode localparams/typedef, matching the 3-bit slice selector encoding;
  - the state enum.
- Sub-module alu_chunk, purely combinational, one CHUNK-bit slice:
  - inputs: a, b, op, carry_in, eq_in, ans_in, top;
  - outputs: result, carry_out, eq_out, ans_out.
- The sequencer owns the FSM, counter, operand/result registers, chunk select and flag logic.

## Test plan
- ADD 0xFFFFFFFF + 0x00000001 → result 0x00000000, carry 1, zero 1, overflow 0; out_valid exactly 8 cycles after the accept.
- SUB 0x80000000 − 0x00000001 → 0x7FFFFFFF, overflow 1, carry 1; SUB 5 − 5 → 0, zero 1.
- SLT a=0xFFFFFFFF, b=0x00000001 → 1; SLT 5,5 → 0; SLT 0x00000010, 0x00000011 → 1.
  - With ALU_SEQ_EARLY_EXIT_EN, the first case raises out_valid 1 cycle after the accept.
  - The 5,5 case still takes 8 cycles.
- a=0xF0F0F0F0, b=0xFF00FF00:
  - AND 0xF000F000, NAND 0x0FFF0FFF, OR 0xFFF0FFF0, NOR 0x000F000F, XOR 0x0FF00FF0.
  - carry and overflow are 0 for all five.
- Hold out_ready low for 5 cycles in DONE:
  - out_* stay stable and in_ready stays 0;
  - an in_valid pulse during those cycles is not accepted;
  - the next op is accepted only after the out_ready handshake.
- Drop rst_n during the 3rd RUN cycle:
  - out_valid never rises;
  - after release, in_ready = 1 and a fresh ADD 2+3 returns 5.
